// File: rtl/logic_op_sequencer_if.sv
// ALU-control side of the logic-op sequencer: start/op/operands in, busy/done/result out.
// With ZERO_FLAG_EN defined the bundle also carries the registered zero flag.
interface logic_op_sequencer_if #(
  parameter int W = 64
);
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] in_0;
  logic [W-1:0] in_1;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
`ifdef ZERO_FLAG_EN
  logic         zero;

  modport master (output start, op, in_0, in_1, input busy, done, result, zero);
  modport slave  (input start, op, in_0, in_1, output busy, done, result, zero);
`else
  modport master (output start, op, in_0, in_1, input busy, done, result);
  modport slave  (input start, op, in_0, in_1, output busy, done, result);
`endif
endinterface

// File: rtl/logic_op_sequencer.sv
// Runs one W-bit AND/OR/XOR/XNOR through a shared CW-bit gate unit, one chunk per cycle, LSB first.
// Define ZERO_FLAG_EN to add a registered result==0 flag on the bus interface.
module logic_op_sequencer #(
  parameter int W  = 64,
  parameter int CW = 16
) (
  input  logic                clk,
  input  logic                rst,
  logic_op_sequencer_if.slave bus,
  output logic [1:0]          gate_op,
  output logic [CW-1:0]       gate_in_0,
  output logic [CW-1:0]       gate_in_1,
  input  logic [CW-1:0]       gate_res
);
  // state | meaning
  // IDLE  | waiting for start, last result held
  // RUN   | one chunk per cycle through the gate unit, cnt selects the chunk
  // DONE  | one-cycle done pulse, result complete
  localparam int N    = W / CW;
  localparam int CNTW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(N - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CNTW-1:0] cnt;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    result_q;
  logic [W-1:0]    result_nxt;
  logic [1:0]      op_q;
  logic            last;

  assign last = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Result with the current gate-unit chunk merged in; also feeds the zero flag.
  always_comb begin
    result_nxt = result_q;
    result_nxt[CW*int'(cnt) +: CW] = gate_res;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_q      <= bus.in_0;
            b_q      <= bus.in_1;
            op_q     <= bus.op;
            cnt      <= '0;
            result_q <= '0;
          end
        end
        RUN: begin
          result_q <= result_nxt;
          if (!last) cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef ZERO_FLAG_EN
  logic zero_q;

  always_ff @(posedge clk) begin
    if (rst)                     zero_q <= 1'b0;
    else if (state == RUN && last) zero_q <= (result_nxt == '0);
  end

  assign bus.zero = zero_q;
`endif

  assign gate_op    = op_q;
  assign gate_in_0  = (state == RUN) ? a_q[CW*int'(cnt) +: CW] : '0;
  assign gate_in_1  = (state == RUN) ? b_q[CW*int'(cnt) +: CW] : '0;
  assign bus.busy   = (state != IDLE);
  assign bus.done   = (state == DONE);
  assign bus.result = result_q;
endmodule

// File: tb/tb_logic_op_sequencer.sv
// Bench for logic_op_sequencer (W=64, CW=16) with an ideal combinational gate unit.
// Directed cases plus random operations checked against a whole-word reference function.
module tb_logic_op_sequencer;
  localparam int W  = 64;
  localparam int CW = 16;
  localparam int N  = W / CW;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    gate_op;
  logic [CW-1:0] gate_in_0;
  logic [CW-1:0] gate_in_1;
  logic [CW-1:0] gate_res;
  int            n_cmp = 0;
  int            n_err = 0;

  logic_op_sequencer_if #(.W(W)) bus ();

  logic_op_sequencer #(.W(W), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .gate_op   (gate_op),
    .gate_in_0 (gate_in_0),
    .gate_in_1 (gate_in_1),
    .gate_res  (gate_res)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (gate_op)
      2'b00:   gate_res = gate_in_0 & gate_in_1;
      2'b01:   gate_res = gate_in_0 | gate_in_1;
      2'b10:   gate_res = gate_in_0 ^ gate_in_1;
      default: gate_res = ~(gate_in_0 ^ gate_in_1);
    endcase
  end

  function automatic logic [W-1:0] ref_op(input logic [1:0] o, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (o)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a ^ b);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full operation with fixed expected timing: chunk k visible in RUN cycle k,
  // done exactly N+1 cycles after the start edge, idle the cycle after.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.in_0 = a; bus.in_1 = b;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (k > 0) @(negedge clk);
      chk({tag, " gin0"}, W'(gate_in_0), W'(a[k*CW +: CW]));
      chk({tag, " gin1"}, W'(gate_in_1), W'(b[k*CW +: CW]));
      chk({tag, " gop"},  W'(gate_op), W'(o));
      chk({tag, " busy_run"}, W'(bus.busy), 1);
      chk({tag, " done_run"}, W'(bus.done), 0);
    end
    @(negedge clk);
    chk({tag, " done"}, W'(bus.done), 1);
    chk({tag, " result"}, bus.result, exp);
`ifdef ZERO_FLAG_EN
    chk({tag, " zero"}, W'(bus.zero), W'(exp == '0));
`endif
    @(negedge clk);
    chk({tag, " done_after"}, W'(bus.done), 0);
    chk({tag, " busy_after"}, W'(bus.busy), 0);
    chk({tag, " result_held"}, bus.result, exp);
    chk({tag, " gin0_idle"}, W'(gate_in_0), 0);
  endtask

  initial begin
    logic [W-1:0] a, b, c, a_late;
    logic [1:0]   o;

    // Reset
    rst = 1'b1; bus.start = 1'b0; bus.op = 2'b00; bus.in_0 = '0; bus.in_1 = '0;
    repeat (3) @(negedge clk);
    chk("rst busy", W'(bus.busy), 0);
    chk("rst done", W'(bus.done), 0);
    chk("rst result", bus.result, 0);
    chk("rst gin0", W'(gate_in_0), 0);
    chk("rst gin1", W'(gate_in_1), 0);
    chk("rst gop", W'(gate_op), 0);
`ifdef ZERO_FLAG_EN
    chk("rst zero", W'(bus.zero), 0);
`endif
    rst = 1'b0;

    run_op("xnor0", 2'b11, '0, '0, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("xor", 2'b10, 64'h0123_4567_89AB_CDEF, 64'hFFFF_0000_FFFF_0000,
           64'hFEDC_4567_7654_CDEF);

    // start held high, in_0 changed during RUN; back-to-back ops with one idle cycle
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; c = {$urandom, $urandom};
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b01; bus.in_0 = a; bus.in_1 = b;
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      chk("hold gin0", W'(gate_in_0), W'(a[k*CW +: CW]));
      bus.in_0 = {$urandom, $urandom};
    end
    @(negedge clk);
    chk("hold done", W'(bus.done), 1);
    chk("hold result", bus.result, a | b);
    bus.in_0 = c;
    @(negedge clk);
    chk("hold gap busy", W'(bus.busy), 0);
    chk("hold gap done", W'(bus.done), 0);
    @(negedge clk);
    chk("hold op2 busy", W'(bus.busy), 1);
    chk("hold op2 gin0", W'(gate_in_0), W'(c[CW-1:0]));
    bus.start = 1'b0;
    repeat (N) @(negedge clk);
    chk("hold op2 done", W'(bus.done), 1);
    chk("hold op2 result", bus.result, c | b);
    @(negedge clk);
    chk("hold op2 idle", W'(bus.busy), 0);

    // Reset after the second chunk aborts the operation
    a_late = {$urandom, $urandom};
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b01; bus.in_0 = a_late; bus.in_1 = ~a_late;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy", W'(bus.busy), 0);
    chk("abort done", W'(bus.done), 0);
    chk("abort result", bus.result, 0);
    chk("abort gin0", W'(gate_in_0), 0);
    chk("abort gop", W'(gate_op), 0);
    repeat (N) begin
      @(negedge clk);
      chk("abort no done", W'(bus.done), 0);
    end
    run_op("and_a", 2'b00, 64'hAAAA_AAAA_AAAA_AAAA, 64'hAAAA_AAAA_AAAA_AAAA,
           64'hAAAA_AAAA_AAAA_AAAA);

    // rst and start on the same edge: rst wins
    @(negedge clk);
    rst = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus.start = 1'b0;
    chk("rst_start busy", W'(bus.busy), 0);
    @(negedge clk);
    chk("rst_start stay idle", W'(bus.busy), 0);
    chk("rst_start result", bus.result, 0);

`ifdef ZERO_FLAG_EN
    run_op("zero_and", 2'b00, 64'hF0F0_F0F0_F0F0_F0F0, 64'h0F0F_0F0F_0F0F_0F0F, 64'h0);
    run_op("zero_or", 2'b01, 64'hF0F0_F0F0_F0F0_F0F0, 64'h0F0F_0F0F_0F0F_0F0F,
           64'hFFFF_FFFF_FFFF_FFFF);
`endif

    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      a = {$urandom, $urandom};
      b = (i % 6 == 5) ? a : {$urandom, $urandom};
      run_op($sformatf("rnd%0d", i), o, a, b, ref_op(o, a, b));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
